// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT results and emits them in natural order.
// One bank is filled while the other is drained, so back-to-back frames stream without gaps.
module fft_out_reorder #(
    parameter int WIDTH = 19,
    parameter int N     = 32,
    parameter int LOG2N = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last
);

    typedef enum logic {IDLE, READ} state_t;

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    logic [WIDTH-1:0] mem_r [2*N];
    logic [WIDTH-1:0] mem_i [2*N];

    state_t           state, state_next;
    logic [LOG2N-1:0] wcnt, rcnt;
    logic             wbank, rbank, rbank_next;
    logic [1:0]       bank_full, full_next;
    logic             rd_en, rd_bank, rd_last, wr_wrap;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = v[LOG2N-1-b];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem_r[{wbank, bitrev(wcnt)}] <= in_r;
            mem_i[{wbank, bitrev(wcnt)}] <= in_i;
        end
    end

    // A bank filling on this edge counts as full when deciding whether the read can chain into it.
    always_comb begin
        rd_en      = 1'b0;
        rd_bank    = rbank;
        rd_last    = 1'b0;
        state_next = state;
        rbank_next = rbank;
        full_next  = bank_full;
        wr_wrap    = in_valid && (wcnt == LAST);
        case (state)
            IDLE: begin
                if (bank_full[0]) begin
                    rd_en   = 1'b1;
                    rd_bank = 1'b0;
                end else if (bank_full[1]) begin
                    rd_en   = 1'b1;
                    rd_bank = 1'b1;
                end
            end
            READ:    rd_en = 1'b1;
            default: rd_en = 1'b0;
        endcase
        if (wr_wrap) begin
            full_next[wbank] = 1'b1;
        end
        if (rd_en) begin
            rd_last    = (rcnt == LAST);
            state_next = READ;
            rbank_next = rd_bank;
            if (rd_last) begin
                full_next[rd_bank] = 1'b0;
                rbank_next         = ~rd_bank;
                if (!full_next[~rd_bank]) begin
                    state_next = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rbank     <= 1'b0;
            rcnt      <= '0;
            wcnt      <= '0;
            wbank     <= 1'b0;
            bank_full <= '0;
        end else begin
            state     <= state_next;
            rbank     <= rbank_next;
            bank_full <= full_next;
            if (in_valid) begin
                wcnt <= wcnt + ONE;
                if (wr_wrap) begin
                    wbank <= ~wbank;
                end
            end
            if (rd_en) begin
                rcnt <= rcnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= rd_en;
            out_last  <= rd_last;
            if (rd_en) begin
                out_r   <= mem_r[{rd_bank, rcnt}];
                out_i   <= mem_i[{rd_bank, rcnt}];
                out_idx <= rcnt;
            end else begin
                out_r   <= '0;
                out_i   <= '0;
                out_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder: bit-reversed frames in, natural-order frames out.
module tb_fft_out_reorder;

    localparam int WIDTH = 19;
    localparam int N     = 32;
    localparam int LOG2N = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_r, in_i;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_r, out_i;
    logic [LOG2N-1:0]        out_idx;
    logic                    out_last;

    typedef struct {
        int r;
        int i;
        int idx;
        int last;
        int cyc;
    } out_rec_t;

    out_rec_t outq[$];
    int checks = 0;
    int errors = 0;
    int neg_cnt = 0;
    int last_in_neg = 0;
    int f0_end = 0;
    int found = 0;

    fft_out_reorder #(.WIDTH(WIDTH), .N(N), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .out_valid(out_valid), .out_r(out_r), .out_i(out_i),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int bitrev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (k[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Record every output beat with the negedge on which it was seen; watch for writes into a full bank.
    always @(negedge clk) begin
        neg_cnt++;
        if (out_valid) begin
            outq.push_back('{r: int'(out_r), i: int'(out_i), idx: int'(out_idx),
                             last: int'(out_last), cyc: neg_cnt});
        end
        if (rst && in_valid) begin
            check_output("no_overflow", int'(dut.bank_full[dut.wbank]), 0);
        end
    end

    task automatic apply_stimulus(input int offset, input int gap, input int special_k);
        int v;
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            v = offset + bitrev5(k);
            in_valid = 1'b1;
            if (k == special_k) begin
                in_r = 19'sh3FFFF;
                in_i = 19'sh40000;
            end else begin
                in_r = 19'(v);
                in_i = 19'(-v);
            end
            last_in_neg = neg_cnt + 1;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic go_idle(input int cycles);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_valid"}, int'(out_valid), 0);
        check_output({tag, "_r"}, int'(out_r), 0);
        check_output({tag, "_i"}, int'(out_i), 0);
        check_output({tag, "_idx"}, int'(out_idx), 0);
        check_output({tag, "_last"}, int'(out_last), 0);
    endtask

    task automatic check_frames(input string tag, input int nframes, input int base,
                                input int special, input int first_neg);
        int f, j, off, er, ei;
        check_output({tag, "_count"}, outq.size(), N * nframes);
        for (int n = 0; n < outq.size() && n < N * nframes; n++) begin
            f   = n / N;
            j   = n % N;
            off = base + 100 * f;
            er  = off + j;
            ei  = -(off + j);
            if (special != 0 && f == 0 && j == 1) begin
                er = 262143;
                ei = -262144;
            end
            check_output($sformatf("%s_f%0d_idx%0d", tag, f, j), outq[n].idx, j);
            check_output($sformatf("%s_f%0d_r%0d", tag, f, j), outq[n].r, er);
            check_output($sformatf("%s_f%0d_i%0d", tag, f, j), outq[n].i, ei);
            check_output($sformatf("%s_f%0d_last%0d", tag, f, j), outq[n].last, int'(j == N - 1));
            check_output($sformatf("%s_f%0d_cyc%0d", tag, f, j), outq[n].cyc, first_neg + 2 + n);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst = 1'b1;

        repeat (100) @(posedge clk);
        #1;
        check_output("idle_no_output", outq.size(), 0);
        check_idle_outputs("idle");

        $display("[TB] single continuous frame");
        outq.delete();
        apply_stimulus(0, 0, -1);
        go_idle(40);
        check_frames("single", 1, 0, 0, last_in_neg);
        check_idle_outputs("after_single");

        $display("[TB] four back-to-back frames");
        outq.delete();
        apply_stimulus(0, 0, -1);
        f0_end = last_in_neg;
        apply_stimulus(100, 0, -1);
        apply_stimulus(200, 0, -1);
        apply_stimulus(300, 0, -1);
        go_idle(40);
        check_frames("b2b", 4, 0, 0, f0_end);

        $display("[TB] toggling in_valid");
        outq.delete();
        apply_stimulus(400, 1, -1);
        go_idle(40);
        check_frames("toggle", 1, 400, 0, last_in_neg);

        $display("[TB] reset mid-write");
        outq.delete();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_r = 19'(900 + k);
            in_i = 19'(-900 - k);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle_outputs("rst_write");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_output("rst_write_no_output", outq.size(), 0);
        apply_stimulus(500, 0, -1);
        go_idle(40);
        check_frames("post_rst_write", 1, 500, 0, last_in_neg);

        $display("[TB] reset mid-read");
        apply_stimulus(600, 0, -1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (out_valid && out_idx == 5'd10) begin
                found = 1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check_output("reached_idx10", found, 1);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_read");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        outq.delete();
        repeat (60) @(posedge clk);
        #1;
        check_output("rst_read_no_output", outq.size(), 0);

        $display("[TB] extreme values after reset");
        apply_stimulus(700, 0, 16);
        go_idle(40);
        check_frames("extreme", 1, 700, 1, last_in_neg);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output reorder buffer for the 32-point SDF FFT pipeline.
- Consumes complex results from the last butterfly stage, which arrive in bit-reversed index order, and emits them in natural order 0..N-1.
- Ping-pong buffered (two N-entry banks), so frames can stream back-to-back with gapless output.
- Sits after the final stage delay line and feeds the chip output pins.

Parameters:
- WIDTH, 19, bit width of each real/imag component.
- N, 32, points per frame; must be a power of two.
- LOG2N, 5, log2(N); width of index counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_r/in_i carry a valid sample this cycle.
- in_r  input  WIDTH  real part, bit-reversed frame order.
- in_i  input  WIDTH  imaginary part, bit-reversed frame order.
- out_valid  output  1  out_r/out_i/out_idx valid this cycle.
- out_r  output  WIDTH  real part, natural order.
- out_i  output  WIDTH  imaginary part, natural order.
- out_idx  output  LOG2N  natural frequency index of the current output.
- out_last  output  1  high with the sample where out_idx == N-1.

Behaviour:
- Reset (rst low, asynchronous):
  - out_valid, out_r, out_i, out_idx, out_last = 0.
  - Write counter, write-bank select, read counter, both bank-full flags and FSM are cleared; FSM goes to IDLE.
  - Bank memory contents are not cleared.
- Write side:
  - On each cycle with in_valid = 1, the sample is stored in the write bank at address bitrev(wcnt), where bitrev reverses LOG2N bits; wcnt then increments.
  - in_valid gaps are allowed; wcnt holds during gaps.
  - When wcnt wraps from N-1 to 0:
    - the write bank's full flag is set;
    - write-bank select toggles, so the next sample goes to the other bank at address bitrev(0) = 0.
- Read FSM, IDLE state:
  - out_valid = 0.
  - When any bank is full, transition to READ on that bank with rcnt = 0.
  - Bank 0 is checked first; only one bank can be full while in IDLE.
- Read FSM, READ state:
  - Each cycle, registered outputs present bank[rcnt] with out_valid = 1 and out_idx = rcnt; rcnt increments.
  - At rcnt = N-1, out_last = 1 and that bank's full flag is cleared on the same edge.
  - If the other bank is full (or becomes full on this same edge), stay in READ on the other bank with rcnt = 0; otherwise go to IDLE.
- Latency: the N-th input of a frame is accepted on edge T; output index 0 appears on edge T+1. Fixed latency of 1 cycle after frame completion.
- Continuous input (in_valid held high) gives continuous output with no bubble between frames.
- Output is never throttled: N consecutive out_valid cycles per frame.
- Simultaneous events:
  - A write filling bank B on the same edge that a read drains bank A is legal; both take effect.
  - The full flag set and clear target different banks, so they never conflict.
- Overflow: not possible. Writing N samples takes at least N cycles and reading N samples takes exactly N cycles, so the write bank is always empty when selected. This is a checked invariant: the bench asserts a write is never directed into a full bank.
- Reset mid-frame:
  - Partially written or partially read frames are discarded.
  - The first frame after reset release starts at wcnt = 0.

Test Plan:
- Reset release, no input -> out_valid stays 0 for 100 cycles; all outputs 0.
- One frame, in_valid continuous: the k-th input has in_r = bitrev5(k), in_i = -bitrev5(k).
  - Required: out_valid high for exactly 32 cycles starting 1 cycle after the 32nd input.
  - Required per output: out_r = out_idx = 0..31 and out_i = -out_idx; out_last only at idx 31.
- Four back-to-back frames (frame f uses in_r = 100*f + bitrev5(k)), in_valid continuous -> 128 consecutive out_valid cycles, no gaps; each frame is in natural order with the correct offset.
- in_valid toggling 1,0 every cycle for one frame -> 32 outputs still emitted contiguously, starting 1 cycle after the 32nd accepted sample; values correct.
- Assert rst low after 20 samples of frame 0 and during the readout of a full frame (at out_idx = 10):
  - Required: outputs drop to 0 immediately (asynchronous).
  - Required: a fresh frame after release is read out correctly with no stale data.
- Max positive/negative values (in_r = 2^18-1, in_i = -2^18) at bit-reversed address 1 (k = 16) -> out_idx 1 shows exactly those values; no sign or width corruption.
